// File: rtl/async_fifo_pkg.sv
// Shared helpers for both pointer domains of the asynchronous FIFO.
// The Gray conversions work on a wide word so that callers of any pointer width can zero-extend into them.
package async_fifo_pkg;

    localparam int ADDR_W_DEFAULT = 3;
    localparam int GRAY_FN_W      = 32;

    function automatic logic [GRAY_FN_W-1:0] bin2gray(input logic [GRAY_FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Prefix XOR from the MSB down, done in log2 steps.
    function automatic logic [GRAY_FN_W-1:0] gray2bin(input logic [GRAY_FN_W-1:0] gray);
        logic [GRAY_FN_W-1:0] bin;
        bin = gray;
        for (int s = 1; s < GRAY_FN_W; s = s * 2) begin
            bin = bin ^ (bin >> s);
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for Gray-coded pointers crossing between clock domains.
// Only one bit of a Gray pointer moves per step, so a late capture yields the old or the new value, never a mix.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // NOTE: non-blocking assignments keep the two stages distinct; blocking would collapse them into one flop.
    always_ff @(posedge clk) begin
        if (srst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/rd_pointer.sv
// Read-side pointer and flag logic of the asynchronous FIFO.
// empty, almost_empty and fill_level come from the synchronized write pointer, so they err on the side of "less data".
module rd_pointer
    import async_fifo_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEFAULT,
    parameter int AE_THRESH = 1
) (
    input  logic              rclk,
    input  logic              rd_srst,
    input  logic              rd_en,
    input  logic [ADDR_W:0]   wptr_gray,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W:0]   rptr_gray,
    output logic              empty,
    output logic              almost_empty,
    output logic              rd_valid,
    output logic [ADDR_W:0]   fill_level
);

    localparam int PTR_W = ADDR_W + 1;

    logic [PTR_W-1:0] rq2;
    logic [PTR_W-1:0] rbin;
    logic [PTR_W-1:0] rbin_next;
    logic [PTR_W-1:0] rgray_next;
    logic [PTR_W-1:0] level_next;
    logic             rd_ok;

    sync_2ff #(.WIDTH(PTR_W)) u_wptr_sync (
        .clk  (rclk),
        .srst (rd_srst),
        .d    (wptr_gray),
        .q    (rq2)
    );

    // Flags look ahead to the post-read pointer so the last read raises empty on the same edge.
    always_comb begin
        rd_ok      = rd_en & ~empty;
        rbin_next  = rbin + PTR_W'(rd_ok);
        rgray_next = PTR_W'(bin2gray(GRAY_FN_W'(rbin_next)));
        level_next = PTR_W'(gray2bin(GRAY_FN_W'(rq2)) - GRAY_FN_W'(rbin_next));
    end

    always_ff @(posedge rclk) begin
        if (rd_srst) begin
            rbin         <= '0;
            rptr_gray    <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            fill_level   <= '0;
            rd_valid     <= 1'b0;
        end else begin
            rbin         <= rbin_next;
            rptr_gray    <= rgray_next;
            empty        <= (rgray_next == rq2);
            almost_empty <= (level_next <= PTR_W'(AE_THRESH));
            fill_level   <= level_next;
            rd_valid     <= rd_ok;
        end
    end

    assign rd_addr = rbin[ADDR_W-1:0];

endmodule

// File: tb/tb_rd_pointer.sv
// Self-checking bench for rd_pointer (ADDR_W=3, AE_THRESH=1): directed scenarios plus randomized read/write traffic.
module tb_rd_pointer;

    localparam int ADDR_W    = 3;
    localparam int AE_THRESH = 1;
    localparam int DEPTH     = 8;
    localparam int MOD       = 16;

    localparam logic [3:0] GRAY_TAB [16] = '{
        4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
        4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
    };

    logic       rclk = 1'b0;
    logic       rd_srst;
    logic       rd_en;
    logic [3:0] wptr_gray;
    logic [2:0] rd_addr;
    logic [3:0] rptr_gray;
    logic       empty;
    logic       almost_empty;
    logic       rd_valid;
    logic [3:0] fill_level;

    always #5 rclk = ~rclk;

    rd_pointer #(.ADDR_W(ADDR_W), .AE_THRESH(AE_THRESH)) dut (
        .rclk         (rclk),
        .rd_srst      (rd_srst),
        .rd_en        (rd_en),
        .wptr_gray    (wptr_gray),
        .rd_addr      (rd_addr),
        .rptr_gray    (rptr_gray),
        .empty        (empty),
        .almost_empty (almost_empty),
        .rd_valid     (rd_valid),
        .fill_level   (fill_level)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: write count seen two edges late, true read count, occupancy as plain modular difference.
    int  wcnt = 0;
    int  m_rcnt = 0, m_w1 = 0, m_w2 = 0, m_fill = 0, rd_total = 0;
    bit  m_empty = 1'b1, m_ae = 1'b1, m_valid = 1'b0, m_rst_last = 1'b1;
    bit  chk_en = 1'b0;

    always @(posedge rclk) begin : model
        int ok;
        int rnext;
        int lvl;
        m_rst_last <= rd_srst;
        if (rd_srst) begin
            m_rcnt   <= 0;
            m_w1     <= 0;
            m_w2     <= 0;
            m_fill   <= 0;
            m_empty  <= 1'b1;
            m_ae     <= 1'b1;
            m_valid  <= 1'b0;
            rd_total <= 0;
        end else begin
            ok    = (rd_en && !m_empty) ? 1 : 0;
            rnext = (m_rcnt + ok) % MOD;
            lvl   = (m_w2 - rnext + MOD) % MOD;
            m_w2     <= m_w1;
            m_w1     <= wcnt % MOD;
            m_rcnt   <= rnext;
            m_fill   <= lvl;
            m_empty  <= (lvl == 0);
            m_ae     <= (lvl <= AE_THRESH);
            m_valid  <= (ok == 1);
            rd_total <= rd_total + ok;
        end
    end

    logic [3:0] prev_rptr = '0;

    always @(negedge rclk) begin
        if (chk_en) begin
            check("empty",        32'(empty),        32'(m_empty));
            check("almost_empty", 32'(almost_empty), 32'(m_ae));
            check("fill_level",   32'(fill_level),   32'(m_fill));
            check("rd_valid",     32'(rd_valid),     32'(m_valid));
            check("rptr_gray",    32'(rptr_gray),    32'(GRAY_TAB[m_rcnt]));
            check("rd_addr",      32'(rd_addr),      32'(m_rcnt % DEPTH));
            if (!m_rst_last && rptr_gray !== prev_rptr)
                check("gray_one_bit_step", 32'($countones(rptr_gray ^ prev_rptr)), 32'd1);
            prev_rptr <= rptr_gray;
        end
    end

    // Apply inputs for exactly one rising edge, then return just after it.
    task automatic step(input bit rst, input bit ren, input int w);
        @(negedge rclk);
        rd_srst   = rst;
        rd_en     = ren;
        wcnt      = w;
        wptr_gray = GRAY_TAB[w % MOD];
        @(posedge rclk);
        #1;
    endtask

    initial begin
        int w;
        bit ren;
        rd_srst   = 1'b1;
        rd_en     = 1'b0;
        wptr_gray = '0;

        // Reset held two cycles
        step(1, 0, 0);
        chk_en = 1'b1;
        step(1, 0, 0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_ae",    32'(almost_empty), 32'd1);
        check("rst_fill",  32'(fill_level), 32'd0);
        check("rst_rptr",  32'(rptr_gray), 32'd0);

        // Write pointer 0 -> 1: empty falls on the third edge
        step(0, 0, 1);
        check("lat_edge1_empty", 32'(empty), 32'd1);
        step(0, 0, 1);
        check("lat_edge2_empty", 32'(empty), 32'd1);
        step(0, 0, 1);
        check("lat_edge3_empty", 32'(empty), 32'd0);
        check("lat_edge3_fill",  32'(fill_level), 32'd1);
        check("lat_edge3_ae",    32'(almost_empty), 32'd1);
        step(0, 1, 1);
        check("lat_read_valid", 32'(rd_valid), 32'd1);
        check("lat_read_empty", 32'(empty), 32'd1);
        check("lat_read_rptr",  32'(rptr_gray), 32'b0001);

        // Underflow: reads while empty are ignored
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1);
            check("uflow_valid", 32'(rd_valid), 32'd0);
            check("uflow_rptr",  32'(rptr_gray), 32'b0001);
        end

        // Full occupancy, then drain to one entry
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 8);
        check("full_fill",  32'(fill_level), 32'd8);
        check("full_ae",    32'(almost_empty), 32'd0);
        check("full_empty", 32'(empty), 32'd0);
        for (int i = 0; i < 7; i++) step(0, 1, 8);
        check("drain_fill",  32'(fill_level), 32'd1);
        check("drain_ae",    32'(almost_empty), 32'd1);
        check("drain_empty", 32'(empty), 32'd0);

        // Mid-read reset with four entries pending
        for (int i = 0; i < 3; i++) step(0, 0, 11);
        check("mid_fill_before", 32'(fill_level), 32'd4);
        step(1, 1, 0);
        check("mid_rst_valid", 32'(rd_valid), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_rptr",  32'(rptr_gray), 32'd0);
        check("mid_rst_addr",  32'(rd_addr), 32'd0);

        // Wrap: sixteen writes and sixteen reads bring both pointers back to zero
        for (int i = 0; i < 400 && rd_total < 16; i++) begin
            w   = wcnt;
            if (wcnt < 16 && (wcnt - rd_total) < DEPTH && $urandom_range(0, 1) == 1) w = wcnt + 1;
            ren = ($urandom_range(0, 2) != 0);
            step(0, ren, w);
        end
        check("wrap_reads_done", 32'(rd_total), 32'd16);
        for (int i = 0; i < 4; i++) step(0, 0, wcnt);
        check("wrap_rptr", 32'(rptr_gray), 32'd0);
        check("wrap_empty", 32'(empty), 32'd1);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                step(1, $urandom_range(0, 1) == 1, 0);
            end else begin
                w = wcnt;
                if ((wcnt - rd_total) < DEPTH && $urandom_range(0, 2) != 0) w = wcnt + 1;
                step(0, $urandom_range(0, 1) == 1, w);
            end
        end

        step(0, 0, wcnt);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
